// File: rtl/clock_control.sv
// Run/step/halt sequencer producing the registered enable for the clock generator.
// Also counts enabled cycles for debug readout.
module clock_control #(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic                   i_run,
    input  logic                   i_step,
    input  logic [COUNT_WIDTH-1:0] i_count,
    input  logic                   i_halt,
    input  logic                   i_clear,
    output logic                   o_enable,
    output logic [1:0]             o_state,
    output logic [31:0]            o_cycles,
    output logic                   o_done
);

    localparam int unsigned CYCLE_WIDTH = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_STEP   = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    logic [1:0]             state_q,     state_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                   enable_q,    enable_d;
    logic                   done_q,      done_d;
    logic [CYCLE_WIDTH-1:0] cycles_q,    cycles_d;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            enable_q    <= 1'b0;
            done_q      <= 1'b0;
            cycles_q    <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            enable_q    <= enable_d;
            done_q      <= done_d;
            cycles_q    <= cycles_d;
        end
    end

    // Next-state; enable follows the next state so it is high exactly in RUN/STEP cycles.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_halt) begin
                    state_d = ST_HALTED;
                end else if (i_step && (i_count != '0)) begin
                    state_d     = ST_STEP;
                    remaining_d = i_count;
                end else if (i_run) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_halt) begin
                    state_d = ST_HALTED;
                end else if (!i_run) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (i_halt) begin
                    state_d     = ST_HALTED;
                    remaining_d = '0;
                end else if (remaining_q == COUNT_WIDTH'(1)) begin
                    state_d     = ST_IDLE;
                    remaining_d = '0;
                    done_d      = 1'b1;
                end else begin
                    remaining_d = remaining_q - COUNT_WIDTH'(1);
                end
            end
            ST_HALTED: begin
                if (i_clear) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                remaining_d = '0;
            end
        endcase

        enable_d = (state_d == ST_RUN) || (state_d == ST_STEP);

        // Clear takes precedence over counting the current enabled cycle.
        if (i_clear) begin
            cycles_d = '0;
        end else if (enable_q) begin
            cycles_d = cycles_q + CYCLE_WIDTH'(1);
        end else begin
            cycles_d = cycles_q;
        end
    end

    assign o_enable = enable_q;
    assign o_state  = state_q;
    assign o_cycles = cycles_q;
    assign o_done   = done_q;

endmodule

// File: tb/tb_clock_control.sv
// Directed bench for clock_control: bursts, run, halt, clear, counter wrap and async reset.
module tb_clock_control;

    localparam int unsigned CW = 16;

    logic          clk;
    logic          rst_n;
    logic          run;
    logic          step;
    logic [CW-1:0] count;
    logic          halt;
    logic          clear;
    logic          enable;
    logic [1:0]    state;
    logic [31:0]   cycles;
    logic          done;

    int total;
    int bad;

    clock_control #(.COUNT_WIDTH(CW)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .i_run     (run),
        .i_step    (step),
        .i_count   (count),
        .i_halt    (halt),
        .i_clear   (clear),
        .o_enable  (enable),
        .o_state   (state),
        .o_cycles  (cycles),
        .o_done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One active edge, then settle 1ns past it before driving or sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        run   = 1'b0;
        step  = 1'b0;
        count = '0;
        halt  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #23;
        total++;
        if ({enable, state, done} !== 4'b0000 || cycles !== 32'd0) begin
            bad++;
            $display("FAIL reset: en=%b st=%0d done=%b cyc=%0d, want 0/0/0/0", enable, state, done, cycles);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (state !== 2'd0 || enable !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: st=%0d en=%b, want 0/0", state, enable);
        end
    endtask

    task automatic test_step_burst();
        int en_cnt;
        int done_cnt;
        en_cnt   = 0;
        done_cnt = 0;
        step  = 1'b1;
        count = CW'(3);
        tick();
        step  = 1'b0;
        count = '0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (enable !== 1'b1 || state !== 2'd2 || done !== 1'b0) begin
                bad++;
                $display("FAIL step3_cycle%0d: en=%b st=%0d done=%b, want 1/2/0", i, enable, state, done);
            end
            if (enable === 1'b1) en_cnt++;
            tick();
        end
        total++;
        if (enable !== 1'b0 || done !== 1'b1 || state !== 2'd0 || cycles !== 32'd3) begin
            bad++;
            $display("FAIL step3_end: en=%b done=%b st=%0d cyc=%0d, want 0/1/0/3", enable, done, state, cycles);
        end
        if (done === 1'b1) done_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done === 1'b1) done_cnt++;
            if (enable === 1'b1) en_cnt++;
        end
        total++;
        if (en_cnt != 3 || done_cnt != 1) begin
            bad++;
            $display("FAIL step3_counts: enabled=%0d done_pulses=%0d, want 3/1", en_cnt, done_cnt);
        end
    endtask

    task automatic test_run();
        int en_cnt;
        en_cnt = 0;
        do_clear();
        for (int i = 0; i < 10; i++) begin
            run   = 1'b1;
            step  = (i == 4);
            count = CW'(2);
            tick();
            total++;
            if (enable !== 1'b1 || state !== 2'd1) begin
                bad++;
                $display("FAIL run_cycle%0d: en=%b st=%0d, want 1/1", i, enable, state);
            end
            if (enable === 1'b1) en_cnt++;
        end
        idle_inputs();
        tick();
        total++;
        if (enable !== 1'b0 || state !== 2'd0 || cycles !== 32'd10 || en_cnt != 10 || done !== 1'b0) begin
            bad++;
            $display("FAIL run_end: en=%b st=%0d cyc=%0d enabled=%0d done=%b, want 0/0/10/10/0",
                     enable, state, cycles, en_cnt, done);
        end
    endtask

    task automatic test_halt_in_burst();
        int done_cnt;
        done_cnt = 0;
        do_clear();
        step  = 1'b1;
        count = CW'(5);
        tick();
        step  = 1'b0;
        tick();
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        total++;
        if (enable !== 1'b0 || state !== 2'd3 || done !== 1'b0 || cycles !== 32'd3) begin
            bad++;
            $display("FAIL halt_burst: en=%b st=%0d done=%b cyc=%0d, want 0/3/0/3", enable, state, done, cycles);
        end
        run   = 1'b1;
        step  = 1'b1;
        count = CW'(4);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done === 1'b1 || enable === 1'b1 || state !== 2'd3) done_cnt++;
        end
        idle_inputs();
        total++;
        if (done_cnt != 0) begin
            bad++;
            $display("FAIL halted_sticky: bad_cycles=%0d, want 0", done_cnt);
        end
        do_clear();
        total++;
        if (state !== 2'd0 || cycles !== 32'd0 || enable !== 1'b0) begin
            bad++;
            $display("FAIL halt_clear: st=%0d cyc=%0d en=%b, want 0/0/0", state, cycles, enable);
        end
    endtask

    task automatic test_clear_with_halt();
        halt = 1'b1;
        tick();
        total++;
        if (state !== 2'd3) begin
            bad++;
            $display("FAIL idle_halt: st=%0d, want 3", state);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++;
        if (state !== 2'd0) begin
            bad++;
            $display("FAIL clear_halt_first: st=%0d, want 0", state);
        end
        tick();
        total++;
        if (state !== 2'd3 || enable !== 1'b0) begin
            bad++;
            $display("FAIL clear_halt_second: st=%0d en=%b, want 3/0", state, enable);
        end
        halt = 1'b0;
        do_clear();
    endtask

    task automatic test_zero_count_and_step_halt();
        step  = 1'b1;
        count = '0;
        tick();
        step = 1'b0;
        total++;
        if (state !== 2'd0 || enable !== 1'b0) begin
            bad++;
            $display("FAIL step_zero: st=%0d en=%b, want 0/0", state, enable);
        end
        step  = 1'b1;
        count = CW'(4);
        halt  = 1'b1;
        tick();
        idle_inputs();
        total++;
        if (state !== 2'd3 || enable !== 1'b0 || cycles !== 32'd0) begin
            bad++;
            $display("FAIL step_with_halt: st=%0d en=%b cyc=%0d, want 3/0/0", state, enable, cycles);
        end
        do_clear();
    endtask

    task automatic test_halt_last_cycle();
        step  = 1'b1;
        count = CW'(2);
        tick();
        step = 1'b0;
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        total++;
        if (state !== 2'd3 || done !== 1'b0 || enable !== 1'b0) begin
            bad++;
            $display("FAIL halt_last: st=%0d done=%b en=%b, want 3/0/0", state, done, enable);
        end
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL halt_last_late_done: done=%b, want 0", done);
        end
        do_clear();
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.cycles_q = 32'hFFFF_FFFE;
        #1;
        release dut.cycles_q;
        run = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if (cycles !== 32'd0) begin
            bad++;
            $display("FAIL wrap_zero: cyc=%h, want 00000000", cycles);
        end
        run = 1'b0;
        tick();
        total++;
        if (cycles !== 32'd1 || state !== 2'd0) begin
            bad++;
            $display("FAIL wrap_one: cyc=%h st=%0d, want 00000001/0", cycles, state);
        end
        run = 1'b1;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++;
        if (cycles !== 32'd0 || state !== 2'd1 || enable !== 1'b1) begin
            bad++;
            $display("FAIL clear_on_enable: cyc=%0d st=%0d en=%b, want 0/1/1", cycles, state, enable);
        end
        run = 1'b0;
        tick();
        total++;
        if (cycles !== 32'd1 || state !== 2'd0) begin
            bad++;
            $display("FAIL clear_then_count: cyc=%0d st=%0d, want 1/0", cycles, state);
        end
    endtask

    task automatic test_reset_mid_burst();
        int late;
        late  = 0;
        step  = 1'b1;
        count = CW'(100);
        tick();
        step = 1'b0;
        for (int i = 1; i < 40; i++) tick();
        total++;
        if (enable !== 1'b1 || state !== 2'd2) begin
            bad++;
            $display("FAIL burst100_c40: en=%b st=%0d, want 1/2", enable, state);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({enable, state, done} !== 4'b0000 || cycles !== 32'd0) begin
            bad++;
            $display("FAIL async_reset: en=%b st=%0d done=%b cyc=%0d, want 0/0/0/0", enable, state, done, cycles);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done !== 1'b0 || enable !== 1'b0) late++;
        end
        total++;
        if (late != 0) begin
            bad++;
            $display("FAIL post_reset_quiet: bad_cycles=%0d, want 0", late);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        idle_inputs();
        test_reset();
        test_step_burst();
        test_run();
        test_halt_in_burst();
        test_clear_with_halt();
        test_zero_count_and_step_halt();
        test_halt_last_cycle();
        test_wrap();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
